// File: rtl/clk_switch_mon_pkg.sv
// clk_switch_mon_pkg: shared FSM state type and fixed widths for the clock switch monitor
package clk_switch_mon_pkg;
  typedef enum logic [1:0] {S_WAIT, S_ACQ, S_LOCK, S_STOP} state_t;
  localparam int GCNT_W = 8;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/clk_switch_mon_sync.sv
// clk_switch_mon_sync: SYNC_DEPTH-flop synchroniser plus edge register (clk, rst, i_d -> o_rise, o_fall, o_lvl)
module clk_switch_mon_sync
  import clk_switch_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall,
  output logic o_lvl
);
  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_edge;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
      r_edge <= r_sync[SYNC_DEPTH-1];
    end
  end
  always_comb begin
    o_lvl  = r_sync[SYNC_DEPTH-1];
    o_rise = o_lvl & ~r_edge;
    o_fall = ~o_lvl & r_edge;
  end
endmodule

// File: rtl/clk_switch_mon.sv
// clk_switch_mon: clk_in period/width/glitch/stop/lock monitor on clk (CLK_SWITCH_MON_MINMAX_EN adds per_min/per_max)
module clk_switch_mon
  import clk_switch_mon_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int MIN_PULSE = 2,
  parameter int TOL       = 1,
  parameter int STABLE_N  = 4,
  parameter int TIMEOUT   = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_in,
  input  logic              clr,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_w,
  output logic [CNT_W-1:0]  low_w,
  output logic              meas_vld,
  output logic              locked,
  output logic              freq_chg,
  output logic              stopped,
  output logic              glitch,
  output logic [GCNT_W-1:0] glitch_cnt
`ifdef CLK_SWITCH_MON_MINMAX_EN
  ,
  output logic [CNT_W-1:0]  per_min,
  output logic [CNT_W-1:0]  per_max
`endif
);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
  localparam int               SW    = $clog2(STABLE_N + 1);
  localparam logic [SW-1:0]    STAB_V = SW'(STABLE_N);
  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_ph_cnt, r_hi_tmp, r_prev_per, w_per, w_diff;
  logic [CNT_W:0]    w_sum;
  logic [SW-1:0]     r_stab_cnt, w_stab_nx;
  logic [GCNT_W-1:0] w_gbase;
  logic              w_rise, w_fall, w_lvl, w_edge, w_active, w_glitch, w_meas, w_tout, w_tol_ok;
  clk_switch_mon_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (clk_in),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_lvl  (w_lvl)
  );
  always_comb begin
    w_edge    = w_rise | w_fall;
    w_active  = r_state == S_ACQ || r_state == S_LOCK;
    w_glitch  = w_active && w_edge && r_ph_cnt < MIN_V;
    w_sum     = {1'b0, r_hi_tmp} + {1'b0, r_ph_cnt};
    w_per     = w_sum[CNT_W] ? CMAX : w_sum[CNT_W-1:0];
    // at a rise r_ph_cnt holds the just-completed low phase; r_hi_tmp still holds a runt high, which discards the period
    w_meas    = w_active && w_rise && !w_glitch && r_hi_tmp >= MIN_V;
    w_diff    = w_per >= r_prev_per ? w_per - r_prev_per : r_prev_per - w_per;
    // stab 0 means no previous valid period to compare with
    w_tol_ok  = r_stab_cnt != '0 && w_diff <= TOL_V;
    w_stab_nx = !w_tol_ok ? SW'(1) : r_stab_cnt >= STAB_V ? STAB_V : r_stab_cnt + SW'(1);
    w_tout    = r_state != S_STOP && !w_edge && r_ph_cnt >= TO_V;
    w_gbase   = clr ? '0 : glitch_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_WAIT;
    else     r_state <= w_state_nx;
  end
  always_comb begin
    w_state_nx = r_state;
    if (w_tout)         w_state_nx = S_STOP;
    else if (!w_active) w_state_nx = w_rise ? S_ACQ : r_state;
    else if (w_glitch)  w_state_nx = S_ACQ;
    else if (w_meas)    w_state_nx = w_stab_nx >= STAB_V ? S_LOCK : S_ACQ;
  end
  always_comb begin
    locked  = r_state == S_LOCK;
    stopped = r_state == S_STOP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph_cnt   <= '0;
      r_hi_tmp   <= '0;
      r_prev_per <= '0;
      r_stab_cnt <= '0;
      period     <= '0;
      high_w     <= '0;
      low_w      <= '0;
      meas_vld   <= 1'b0;
      freq_chg   <= 1'b0;
      glitch     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      r_ph_cnt   <= w_edge ? CNT_W'(1) : r_ph_cnt == CMAX ? CMAX : r_ph_cnt + CNT_W'(1);
      r_hi_tmp   <= w_edge && !w_lvl ? r_ph_cnt : r_hi_tmp;
      r_prev_per <= w_meas ? w_per : r_prev_per;
      r_stab_cnt <= w_meas ? w_stab_nx : w_active && !w_glitch && !w_tout ? r_stab_cnt : '0;
      period     <= w_meas ? w_per : period;
      high_w     <= w_meas ? r_hi_tmp : high_w;
      low_w      <= w_meas ? r_ph_cnt : low_w;
      meas_vld   <= w_meas;
      freq_chg   <= r_state == S_LOCK && (w_glitch || (w_meas && !w_tol_ok));
      // a glitch coinciding with clr counts from the cleared value
      glitch     <= w_glitch || (glitch && !clr);
      glitch_cnt <= w_glitch && w_gbase != '1 ? w_gbase + GCNT_W'(1) : w_gbase;
    end
  end
`ifdef CLK_SWITCH_MON_MINMAX_EN
  logic [CNT_W-1:0] w_min_b, w_max_b;
  always_comb begin
    w_min_b = clr ? CMAX : per_min;
    w_max_b = clr ? '0 : per_max;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      per_min <= CMAX;
      per_max <= '0;
    end else begin
      per_min <= w_meas && w_per < w_min_b ? w_per : w_min_b;
      per_max <= w_meas && w_per > w_max_b ? w_per : w_max_b;
    end
  end
`endif
endmodule

// File: tb/tb_clk_switch_mon.sv
// tb_clk_switch_mon: directed scenarios with a behavioural model checked every cycle
module tb_clk_switch_mon;
  localparam int MINP = 2, TOLP = 1, STN = 4, TO = 512, CMX = 1023;
  logic       clk = 0, rst = 1, clk_in = 0, clr = 0;
  logic [9:0] period, high_w, low_w;
  logic       meas_vld, locked, freq_chg, stopped, glitch;
  logic [7:0] glitch_cnt;
`ifdef CLK_SWITCH_MON_MINMAX_EN
  logic [9:0] per_min, per_max;
  logic [9:0] e_min, e_max;
`endif
  clk_switch_mon dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .clr        (clr),
    .period     (period),
    .high_w     (high_w),
    .low_w      (low_w),
    .meas_vld   (meas_vld),
    .locked     (locked),
    .freq_chg   (freq_chg),
    .stopped    (stopped),
    .glitch     (glitch),
    .glitch_cnt (glitch_cnt)
`ifdef CLK_SWITCH_MON_MINMAX_EN
    ,
    .per_min    (per_min),
    .per_max    (per_max)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int n_meas = 0, n_fchg = 0, lock_at = 0, first_per = -1, first_hi = -1, first_lo = -1;
  bit started = 0;
  int h1, h2, h3, run, mode, streak, hi, last, p, cur, prv;
  bit ed, rs, ok, lk;
  logic [9:0] e_period, e_high, e_low;
  logic       e_meas, e_locked, e_fchg, e_stopped, e_glitch;
  logic [7:0] e_gcnt;
  // model: works on whole phases as seen two samples late; mode 0 idle, 1 tracking, 2 stopped
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0; run = 0; mode = 0; streak = 0; hi = 0; last = 0; lk = 0;
      e_period = 0; e_high = 0; e_low = 0; e_meas = 0; e_locked = 0; e_fchg = 0;
      e_stopped = 0; e_glitch = 0; e_gcnt = 0;
`ifdef CLK_SWITCH_MON_MINMAX_EN
      e_min = 10'(CMX); e_max = 0;
`endif
    end else begin
      cur = h2; prv = h3; h3 = h2; h2 = h1; h1 = int'(clk_in);
      ed = cur != prv;
      rs = ed && cur == 1;
      e_meas = 0; e_fchg = 0;
`ifdef CLK_SWITCH_MON_MINMAX_EN
      if (clr) begin e_min = 10'(CMX); e_max = 0; end
`endif
      if (mode == 1 && ed && run < MINP) begin
        e_glitch = 1;
        if (clr) e_gcnt = 0;
        if (e_gcnt != 8'd255) e_gcnt = e_gcnt + 8'd1;
        if (lk) e_fchg = 1;
        lk = 0; streak = 0;
      end else begin
        if (clr) begin e_glitch = 0; e_gcnt = 0; end
        if (mode == 1 && rs && hi >= MINP) begin
          p = (hi + run > CMX) ? CMX : hi + run;
          ok = streak > 0 && ((p > last) ? p - last : last - p) <= TOLP;
          if (!ok && lk) e_fchg = 1;
          streak = ok ? ((streak + 1 > STN) ? STN : streak + 1) : 1;
          lk = streak >= STN;
          last = p;
          e_period = 10'(p); e_high = 10'(hi); e_low = 10'(run); e_meas = 1;
`ifdef CLK_SWITCH_MON_MINMAX_EN
          if (10'(p) < e_min) e_min = 10'(p);
          if (10'(p) > e_max) e_max = 10'(p);
`endif
        end
      end
      if (mode != 2 && !ed && run >= TO) begin mode = 2; lk = 0; streak = 0; end
      else if (mode != 1 && rs) begin mode = 1; streak = 0; end
      if (ed && cur == 0) hi = run;
      run = ed ? 1 : (run >= CMX ? CMX : run + 1);
      e_locked = lk;
      e_stopped = mode == 2;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      n_chk++;
      if ({period, high_w, low_w, meas_vld, locked, freq_chg, stopped, glitch, glitch_cnt} !==
          {e_period, e_high, e_low, e_meas, e_locked, e_fchg, e_stopped, e_glitch, e_gcnt}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got per=%0d hi=%0d lo=%0d mv=%0b lk=%0b fc=%0b st=%0b g=%0b gc=%0d exp per=%0d hi=%0d lo=%0d mv=%0b lk=%0b fc=%0b st=%0b g=%0b gc=%0d",
                 $time, period, high_w, low_w, meas_vld, locked, freq_chg, stopped, glitch, glitch_cnt,
                 e_period, e_high, e_low, e_meas, e_locked, e_fchg, e_stopped, e_glitch, e_gcnt);
      end
`ifdef CLK_SWITCH_MON_MINMAX_EN
      n_chk++;
      if ({per_min, per_max} !== {e_min, e_max}) begin
        n_fail++;
        $display("FAIL minmax_cmp t=%0t got min=%0d max=%0d exp min=%0d max=%0d", $time, per_min, per_max, e_min, e_max);
      end
`endif
      if (meas_vld === 1'b1) begin
        if (n_meas == 0) begin first_per = period; first_hi = high_w; first_lo = low_w; end
        n_meas++;
      end
      if (locked === 1'b1 && lock_at == 0) lock_at = n_meas;
      if (freq_chg === 1'b1) n_fchg++;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic ph(input logic lv, input int n);
    clk_in = lv;
    repeat (n) @(negedge clk);
  endtask
  task automatic per(input int h, input int l);
    ph(1'b1, h);
    ph(1'b0, l);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int base, mb, lat;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (6) per(10, 10);
    ph(1'b1, 3);
    #1;
    chk("first_period", first_per, 20);
    chk("first_high", first_hi, 10);
    chk("first_low", first_lo, 10);
    chk("model_first_period", int'(e_period), 20);
    chk("lock_at_meas", lock_at, 4);
    chk("locked_basic", int'(locked), 1);
    ph(1'b1, 7);
    base = n_fchg;
    ph(1'b0, 3);
    repeat (3) begin per(3, 3); per(3, 2); end
    ph(1'b1, 3);
    #1;
    chk("switch_fchg_pulses", n_fchg - base, 1);
    chk("switch_relocked", int'(locked), 1);
    chk("switch_glitch", int'(glitch), 0);
    chk("switch_period", int'(period), 5);
    chk("model_switch_period", int'(e_period), 5);
    ph(1'b0, 3);
    base = n_fchg;
    mb = n_meas;
    per(1, 3);
    ph(1'b1, 3);
    #1;
    chk("runt_glitch", int'(glitch), 1);
    chk("runt_gcnt", int'(glitch_cnt), 1);
    chk("runt_locked", int'(locked), 0);
    chk("runt_fchg", n_fchg - base, 1);
    chk("runt_meas_only_prior", n_meas - mb, 1);
    chk("model_runt_gcnt", int'(e_gcnt), 1);
    clk_in = 0;
    lat = 0;
    while (stopped !== 1'b1 && lat < 700) begin
      @(negedge clk);
      lat++;
    end
    #1;
    chk("stop_latency", lat, 515);
    chk("stop_locked", int'(locked), 0);
    mb = n_meas;
    ph(1'b1, 4);
    #1;
    chk("restart_stopped", int'(stopped), 0);
    chk("restart_no_meas", n_meas - mb, 0);
    ph(1'b0, 3);
    ph(1'b1, 4);
    #1;
    chk("restart_meas", n_meas - mb, 1);
    chk("restart_period", int'(period), 7);
    ph(1'b0, 3);
    clk_in = 1;
    @(negedge clk);
    clk_in = 0;
    @(negedge clk);
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    #1;
    chk("collide_glitch", int'(glitch), 1);
    chk("collide_gcnt", int'(glitch_cnt), 1);
    ph(1'b0, 4);
    clr = 1;
    @(negedge clk);
    clr = 0;
    #1;
    chk("clr_glitch", int'(glitch), 0);
    chk("clr_gcnt", int'(glitch_cnt), 0);
    repeat (6) per(10, 10);
    ph(1'b1, 3);
    #1;
    chk("relock_before_rst", int'(locked), 1);
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_w), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_meas", int'(meas_vld), 0);
    rst = 0;
    mb = n_meas;
    ph(1'b1, 4);
    ph(1'b0, 10);
    #1;
    chk("rst_first_rise_no_meas", n_meas - mb, 0);
    ph(1'b1, 4);
    #1;
    chk("rst_second_rise_meas", n_meas - mb, 1);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
